// File: rtl/khazad_ps_bridge.sv
// PS 32-bit register bus to KHAZAD core bridge: key/data staging, launch/wait FSM,
// result capture, status, latency count and completion/timeout interrupt.
module khazad_ps_bridge #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [3:0]   wr_addr,
  input  logic [31:0]  wr_data,
  input  logic         rd_en,
  input  logic [3:0]   rd_addr,
  output logic [31:0]  rd_data,
  output logic [127:0] core_key,
  output logic [63:0]  core_din,
  output logic         core_mode,
  output logic         core_start,
  input  logic         core_done,
  input  logic [63:0]  core_dout,
  output logic         irq
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;

  state_t           state;
  logic [63:0]      dout_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] latency_q;
  logic             done_q;
  logic             err_q;
  logic             timeout_q;

  logic        busy_c;
  logic        reg_wr_c;
  logic        ctrl_wr_c;
  logic [31:0] rd_mux_c;

  assign busy_c    = (state != S_IDLE);
  assign reg_wr_c  = wr_en && (wr_addr < 4'd6);
  assign ctrl_wr_c = wr_en && (wr_addr == 4'd6);

  // Read mux; unmapped words return zero
  always_comb begin
    rd_mux_c = 32'h0;
    case (rd_addr)
      4'd0:    rd_mux_c = core_key[127:96];
      4'd1:    rd_mux_c = core_key[95:64];
      4'd2:    rd_mux_c = core_key[63:32];
      4'd3:    rd_mux_c = core_key[31:0];
      4'd4:    rd_mux_c = core_din[63:32];
      4'd5:    rd_mux_c = core_din[31:0];
      4'd6:    rd_mux_c = {28'h0, timeout_q, err_q, done_q, busy_c};
      4'd8:    rd_mux_c = dout_q[63:32];
      4'd9:    rd_mux_c = dout_q[31:0];
      4'd10:   rd_mux_c = 32'(latency_q);
      default: rd_mux_c = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      core_key   <= '0;
      core_din   <= '0;
      core_mode  <= 1'b0;
      core_start <= 1'b0;
      irq        <= 1'b0;
      rd_data    <= '0;
      dout_q     <= '0;
      cnt_q      <= '0;
      latency_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      core_start <= 1'b0;
      irq        <= 1'b0;
      if (rd_en) rd_data <= rd_mux_c;

      if (!busy_c) begin
        if (reg_wr_c) begin
          case (wr_addr)
            4'd0:    core_key[127:96] <= wr_data;
            4'd1:    core_key[95:64]  <= wr_data;
            4'd2:    core_key[63:32]  <= wr_data;
            4'd3:    core_key[31:0]   <= wr_data;
            4'd4:    core_din[63:32]  <= wr_data;
            default: core_din[31:0]   <= wr_data;
          endcase
        end
        // Clear is applied before a same-cycle start
        if (ctrl_wr_c && wr_data[2]) begin
          done_q    <= 1'b0;
          err_q     <= 1'b0;
          timeout_q <= 1'b0;
        end
        if (ctrl_wr_c && wr_data[0]) begin
          core_mode  <= wr_data[1];
          done_q     <= 1'b0;
          timeout_q  <= 1'b0;
          latency_q  <= '0;
          core_start <= 1'b1;
          state      <= S_LAUNCH;
        end
      end else begin
        // Staging registers are frozen while the core runs
        if (reg_wr_c || (ctrl_wr_c && wr_data[0])) begin
          err_q <= 1'b1;
        end else if (ctrl_wr_c && wr_data[2]) begin
          err_q     <= 1'b0;
          timeout_q <= 1'b0;
        end
      end

      case (state)
        S_LAUNCH: begin
          cnt_q <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (core_done) begin
            dout_q    <= core_dout;
            latency_q <= cnt_q + 1'b1;
            done_q    <= 1'b1;
            irq       <= 1'b1;
            state     <= S_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            timeout_q <= 1'b1;
            irq       <= 1'b1;
            state     <= S_IDLE;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_IDLE: ;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_khazad_ps_bridge.sv
// Directed bench for khazad_ps_bridge: register map, launch/complete, busy writes,
// timeout, done-vs-timeout race and mid-operation reset.
module tb_khazad_ps_bridge;

  logic         clk;
  logic         rst_n;
  logic         wr_en;
  logic [3:0]   wr_addr;
  logic [31:0]  wr_data;
  logic         rd_en;
  logic [3:0]   rd_addr;
  logic [31:0]  rd_data;
  logic [127:0] core_key;
  logic [63:0]  core_din;
  logic         core_mode;
  logic         core_start;
  logic         core_done;
  logic [63:0]  core_dout;
  logic         irq;

  int n_checks = 0;
  int n_pass   = 0;
  int irq_cnt  = 0;
  int start_cnt = 0;

  khazad_ps_bridge #(.TIMEOUT(8), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .core_key   (core_key),
    .core_din   (core_din),
    .core_mode  (core_mode),
    .core_start (core_start),
    .core_done  (core_done),
    .core_dout  (core_dout),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (irq) irq_cnt <= irq_cnt + 1;
    if (core_start) start_cnt <= start_cnt + 1;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    rd_en = 1'b1; rd_addr = a;
    @(negedge clk);
    rd_en = 1'b0;
    d = rd_data;
  endtask

  // Negedges until irq is seen, bounded
  task automatic wait_irq(output int n);
    n = 0;
    while (!irq && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int n;
    int irq_snap;
    int addrs[10] = '{0, 1, 2, 3, 4, 5, 6, 8, 9, 10};

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0; core_done = 1'b0; core_dout = '0;
    repeat (3) @(negedge clk);
    check("rst_rd_data", rd_data, 0);
    check("rst_start", core_start, 0);
    check("rst_irq", irq, 0);
    check("rst_key", core_key, 0);
    check("rst_mode", core_mode, 0);
    rst_n = 1'b1;
    @(negedge clk);
    rd(4'd6, d); check("rst_status", d, 0);

    // Staging, readback and launch
    wr(4'd0, 32'h00112233); wr(4'd1, 32'h44556677);
    wr(4'd2, 32'h8899AABB); wr(4'd3, 32'hCCDDEEFF);
    wr(4'd4, 32'h01234567); wr(4'd5, 32'h89ABCDEF);
    wr(4'd7, 32'hFFFFFFFF);
    check("key", core_key, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    check("din", core_din, 64'h01234567_89ABCDEF);
    rd(4'd1, d); check("rd_key1", d, 32'h44556677);
    rd(4'd5, d); check("rd_din1", d, 32'h89ABCDEF);
    rd(4'd7, d); check("rd_unmapped7", d, 0);
    rd(4'd15, d); check("rd_unmapped15", d, 0);
    wr(4'd6, 32'h1);
    check("start_hi", core_start, 1);
    check("mode_enc", core_mode, 0);
    @(negedge clk);
    check("start_lo", core_start, 0);
    rd(4'd6, d); check("busy_status", d, 32'h1);
    repeat (3) @(negedge clk);
    core_done = 1'b1; core_dout = 64'hDEADBEEF_CAFEF00D;
    @(negedge clk);
    core_done = 1'b0; core_dout = '0;
    check("t1_irq_hi", irq, 1);
    @(negedge clk);
    check("t1_irq_lo", irq, 0);
    check("t1_irq_cnt", irq_cnt, 1);
    check("t1_start_cnt", start_cnt, 1);
    rd(4'd6, d); check("t1_status", d, 32'h2);
    rd(4'd8, d); check("t1_dout_hi", d, 32'hDEADBEEF);
    rd(4'd9, d); check("t1_dout_lo", d, 32'hCAFEF00D);
    rd(4'd10, d); check("t1_latency", d, 5);

    // Writes while busy are dropped and flag err
    wr(4'd6, 32'h1);
    wr(4'd0, 32'hFFFFFFFF);
    wr(4'd6, 32'h1);
    rd(4'd6, d); check("t3_status_err", d, 32'h5);
    check("t3_key_kept", core_key, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    wr(4'd6, 32'h4);
    rd(4'd6, d); check("t3_status_clr", d, 32'h1);
    wait_irq(n);
    check("t3_irq", irq, 1);
    @(negedge clk);
    rd(4'd6, d); check("t3_status_to", d, 32'h8);
    check("t3_start_cnt", start_cnt, 2);

    // Timeout with decrypt mode; result registers untouched
    wr(4'd6, 32'h3);
    check("t4_mode_dec", core_mode, 1);
    wait_irq(n);
    check("t4_cycles", n, 9);
    @(negedge clk);
    check("t4_irq_lo", irq, 0);
    check("t4_irq_cnt", irq_cnt, 3);
    rd(4'd6, d); check("t4_status", d, 32'h8);
    rd(4'd8, d); check("t4_dout_hi", d, 32'hDEADBEEF);
    rd(4'd9, d); check("t4_dout_lo", d, 32'hCAFEF00D);
    rd(4'd10, d); check("t4_latency", d, 0);

    // Clear+start together, done on the timeout cycle
    wr(4'd6, 32'h5);
    repeat (8) @(negedge clk);
    core_done = 1'b1; core_dout = 64'h11111111_22222222;
    @(negedge clk);
    core_done = 1'b0; core_dout = '0;
    check("t5_irq", irq, 1);
    @(negedge clk);
    rd(4'd6, d); check("t5_status", d, 32'h2);
    rd(4'd10, d); check("t5_latency", d, 8);
    rd(4'd8, d); check("t5_dout_hi", d, 32'h11111111);

    // Spurious done while idle
    irq_snap = irq_cnt;
    core_done = 1'b1; core_dout = 64'h33333333_44444444;
    @(negedge clk);
    core_done = 1'b0; core_dout = '0;
    @(negedge clk);
    check("t5_spur_irq", irq_cnt, irq_snap);
    rd(4'd6, d); check("t5_spur_status", d, 32'h2);
    rd(4'd9, d); check("t5_spur_dout", d, 32'h22222222);
    check("t5_start_cnt", start_cnt, 4);

    // Reset in the middle of WAIT
    wr(4'd6, 32'h1);
    repeat (3) @(negedge clk);
    rd(4'd8, d); check("t6_pre_rd", d, 32'h11111111);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_rd_data", rd_data, 0);
    check("t6_rst_start", core_start, 0);
    check("t6_rst_irq", irq, 0);
    check("t6_rst_key", core_key, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rd(4'(addrs[i]), d);
      check($sformatf("t6_rd%0d", addrs[i]), d, 0);
    end
    check("t6_irq_cnt", irq_cnt, 4);
    check("t6_start_cnt", start_cnt, 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
